// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/reset sequencer gating the cpu core via core_ce and core_reset
// Optional RUN_CTRL_CYCLE_LIMIT_EN adds a cycle_limit input that halts RUN at a fixed cycle count.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESET_HOLD      = 16,
  parameter int SAMPLE_DIV_W    = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_reset,
  input  logic        btn_step,
  input  logic        sw_run,
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  input  logic [31:0] cycle_limit,
`endif
  output logic        core_reset,
  output logic        core_ce,
  output logic [31:0] run_cycles,
  output logic [1:0]  state,
  output logic        led_strobe
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HALT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    core_reset_q, core_reset_d;
  logic                    core_ce_q, core_ce_d;
  logic [31:0]             run_cycles_q, run_cycles_d;
  logic [SAMPLE_DIV_W-1:0] div_q, div_d;
  logic [2:0]              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]              deb_q, deb_d;
  logic [1:0]              deb_prev_q, deb_prev_d;
  logic [DB_W-1:0]         db_cnt_q [3];
  logic [DB_W-1:0]         db_cnt_d [3];

  logic reset_edge, step_edge, run_lvl, limit_hit;

  // Bit order in the input vectors: 0 = btn_reset, 1 = btn_step, 2 = sw_run.
  always_comb begin
    sync1_d = {sw_run, btn_step, btn_reset};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
    deb_prev_d = deb_q[1:0];
  end

  assign reset_edge = deb_q[0] & ~deb_prev_q[0];
  assign step_edge  = deb_q[1] & ~deb_prev_q[1];
  assign run_lvl    = deb_q[2];

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  assign limit_hit = (cycle_limit != 32'd0) && (run_cycles_q + 32'd1 == cycle_limit) && core_ce_q;
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_RESET: begin
        if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_d = run_lvl ? ST_RUN : ST_HALT;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (run_lvl)        state_d = ST_RUN;
        else if (step_edge) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (!run_lvl || limit_hit) state_d = ST_HALT;
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
    // A reset press overrides every other transition, including a coincident step.
    if (reset_edge) begin
      state_d = ST_RESET;
      hold_d  = '0;
    end
    core_reset_d = (state_d == ST_RESET);
    core_ce_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    run_cycles_d = reset_edge ? 32'd0 : run_cycles_q + {31'd0, core_ce_q};
    div_d        = div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESET;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
      core_ce_q    <= 1'b0;
      run_cycles_q <= '0;
      div_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      deb_prev_q   <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      core_reset_q <= core_reset_d;
      core_ce_q    <= core_ce_d;
      run_cycles_q <= run_cycles_d;
      div_q        <= div_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_prev_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign core_reset = core_reset_q;
  assign core_ce    = core_ce_q;
  assign run_cycles = run_cycles_q;
  assign state      = state_q;
  assign led_strobe = &div_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_reset = 1'b0;
  logic        btn_step = 1'b0;
  logic        sw_run = 1'b0;
  logic        core_reset, core_ce, led_strobe;
  logic [31:0] run_cycles;
  logic [1:0]  state;
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
  logic [31:0] cycle_limit = 32'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt;
  int pulses;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD(3),
    .SAMPLE_DIV_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_reset(btn_reset),
    .btn_step(btn_step),
    .sw_run(sw_run),
`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    .cycle_limit(cycle_limit),
`endif
    .core_reset(core_reset),
    .core_ce(core_ce),
    .run_cycles(run_cycles),
    .state(state),
    .led_strobe(led_strobe)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic press_step(output int n);
    n = 0;
    btn_step = 1'b1;
    repeat (8) begin
      wait_cyc(1);
      if (core_ce) n++;
    end
    btn_step = 1'b0;
    repeat (8) begin
      wait_cyc(1);
      if (core_ce) n++;
    end
  endtask

  // Bench-side count of clock edges since reset release; strobe expected on every 16th.
  always @(posedge clk or posedge reset) begin
    if (reset) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    check("led_strobe", led_strobe, (ecnt % 16 == 15) ? 1 : 0);
    check("ce_with_reset", core_ce & core_reset, 0);
  end

  initial begin
    wait_cyc(2);
    check("rst_core_reset", core_reset, 1);
    check("rst_core_ce", core_ce, 0);
    check("rst_run_cycles", run_cycles, 0);
    check("rst_state", state, 0);
    check("rst_strobe", led_strobe, 0);
    reset = 1'b0;
    wait_cyc(2);
    check("hold_state", state, 0);
    check("hold_core_reset", core_reset, 1);
    wait_cyc(1);
    check("po_state", state, 1);
    check("po_core_reset", core_reset, 0);
    check("po_core_ce", core_ce, 0);
    check("po_run_cycles", run_cycles, 0);

    sw_run = 1'b1;
    wait_cyc(6);
    check("run_not_early", state, 1);
    wait_cyc(1);
    check("run_state", state, 2);
    check("run_ce", core_ce, 1);
    check("run_rc0", run_cycles, 0);
    wait_cyc(1);
    check("run_rc1", run_cycles, 1);
    wait_cyc(12);
    sw_run = 1'b0;
    wait_cyc(6);
    check("halt_not_early", state, 2);
    check("run_rc19", run_cycles, 19);
    wait_cyc(1);
    check("halt_state", state, 1);
    check("halt_ce", core_ce, 0);
    check("halt_rc20", run_cycles, 20);
    wait_cyc(3);
    check("halt_rc_frozen", run_cycles, 20);

    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(3);
    check("step_pre_state", state, 1);
    for (int p = 0; p < 3; p++) begin
      press_step(pulses);
      check("step_pulse", pulses, 1);
    end
    check("step_rc", run_cycles, 3);
    check("step_state", state, 1);

    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      btn_step = ((i / 2) % 2 == 0);
      wait_cyc(1);
      if (core_ce) pulses++;
    end
    btn_step = 1'b0;
    repeat (10) begin
      wait_cyc(1);
      if (core_ce) pulses++;
    end
    check("bounce_ce", pulses, 0);
    check("bounce_state", state, 1);
    check("bounce_rc", run_cycles, 3);

    sw_run = 1'b1;
    wait_cyc(7);
    check("prio_run", state, 2);
    wait_cyc(3);
    btn_reset = 1'b1;
    btn_step  = 1'b1;
    wait_cyc(6);
    check("prio_not_early", state, 2);
    wait_cyc(1);
    check("prio_state", state, 0);
    check("prio_ce", core_ce, 0);
    check("prio_rc", run_cycles, 0);
    check("prio_core_reset", core_reset, 1);
    wait_cyc(2);
    check("prio_hold_state", state, 0);
    check("prio_hold_reset", core_reset, 1);
    wait_cyc(1);
    check("prio_rerun_state", state, 2);
    check("prio_rerun_reset", core_reset, 0);
    check("prio_rerun_ce", core_ce, 1);
    btn_reset = 1'b0;
    btn_step  = 1'b0;
    wait_cyc(1);
    check("prio_rerun_rc", run_cycles, 1);

    wait_cyc(4);
    reset = 1'b1;
    #1;
    check("async_state", state, 0);
    check("async_core_reset", core_reset, 1);
    check("async_ce", core_ce, 0);
    check("async_rc", run_cycles, 0);
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(3);
    check("async_halt_first", state, 1);
    wait_cyc(4);
    check("async_run_again", state, 2);

`ifdef RUN_CTRL_CYCLE_LIMIT_EN
    sw_run = 1'b0;
    reset  = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(3);
    check("lim_pre_state", state, 1);
    cycle_limit = 32'd10;
    sw_run = 1'b1;
    wait_cyc(7);
    check("lim_run", state, 2);
    check("lim_rc0", run_cycles, 0);
    wait_cyc(9);
    check("lim_rc9", run_cycles, 9);
    check("lim_still_run", state, 2);
    wait_cyc(1);
    check("lim_halt", state, 1);
    check("lim_rc10", run_cycles, 10);
    check("lim_ce", core_ce, 0);
    wait_cyc(1);
    check("lim_free_run", state, 2);
    wait_cyc(1);
    check("lim_rc11", run_cycles, 11);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/reset sequencer between the Basys3 board inputs and the `cpu` core. It debounces raw buttons and switches, and holds the core in reset for a fixed number of cycles. It gates the core through a clock-enable for free-run, halt and single-step operation. It also maintains an enabled-cycle counter and a periodic LED sample strobe for the board-level display register.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required before a synchronized input is accepted (10 ms at 100 MHz); minimum 1.
- `RESET_HOLD`, 16: cycles `core_reset` stays high after entering RESET; minimum 1.
- `SAMPLE_DIV_W`, 26: width of the free-running LED sample divider.

Ports:
- `clk`  in  1  system clock; the sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_reset`  in  1  raw, asynchronous reset button.
- `btn_step`  in  1  raw, asynchronous single-step button.
- `sw_run`  in  1  raw, asynchronous run switch (level; 1 = run).
- `core_reset`  out  1  registered reset to the core.
- `core_ce`  out  1  registered clock-enable to the core.
- `run_cycles`  out  32  count of cycles with `core_ce`=1.
- `state`  out  2  current state: 0 = RESET, 1 = HALT, 2 = RUN, 3 = STEP.
- `led_strobe`  out  1  one-cycle pulse every 2^SAMPLE_DIV_W cycles.

## Operation
- Each raw input passes through a 2-flop synchronizer, then a debouncer. The debounced value updates only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the stability counter.
- Rising-edge detect is applied to debounced `btn_reset` and `btn_step`. `sw_run` is used as a debounced level.
- State machine:
  - RESET: `core_reset`=1 and `core_ce`=0. The hold counter counts `RESET_HOLD` cycles. On expiry, go to RUN if debounced `sw_run`=1, otherwise HALT.
  - HALT: `core_ce`=0. A `sw_run` level of 1 goes to RUN. A step edge goes to STEP.
  - RUN: `core_ce`=1. A `sw_run` level of 0 goes to HALT.
  - STEP: `core_ce`=1 for exactly one cycle, then HALT unconditionally.
- Priority: a `btn_reset` edge in any state goes to RESET, reloads the hold counter and clears `run_cycles`. This overrides a simultaneous step edge or run-level change.
- Ignored inputs:
  - Step edges in RUN, STEP and RESET are dropped, not queued.
  - Step edges coinciding with `sw_run`=1 in HALT are dropped; RUN wins.
- `run_cycles` increments by 1 on each cycle where registered `core_ce`=1, and wraps from 0xFFFFFFFF to 0.
- The LED divider is free-running and independent of the state machine. `led_strobe` is high for the cycle in which the divider equals all-ones.

## Timing
- Reset values (async `reset` high):
  - `core_reset`=1, `core_ce`=0, `run_cycles`=0, `state`=0, `led_strobe`=0.
  - Divider, debouncers, synchronizers and edge detectors are all 0.
- After `reset` deasserts: `core_reset` stays 1 for `RESET_HOLD` cycles, then falls together with the `state` update.
- Raw input to debounced change: 2 + `DEBOUNCE_CYCLES` cycles. Debounced edge or level to `state`/`core_ce` change: 1 cycle.
- `core_ce` and `core_reset` are registered and change on the same edge as `state`.
- `run_cycles` reflects a `core_ce`=1 cycle one cycle later.
- A `btn_reset` edge during RUN sets `core_ce`=0 and `core_reset`=1 on the same next edge; the core never sees enable and reset together.
- Async `reset` mid-RUN or mid-STEP immediately forces all reset values. The sequence restarts from RESET with a full hold.

## Configuration
- `RUN_CTRL_CYCLE_LIMIT_EN` defined: adds input `cycle_limit` (32 bits).
  - In RUN, if `cycle_limit` is nonzero and `run_cycles` + 1 == `cycle_limit` while `core_ce`=1, the next state is HALT.
  - `run_cycles` therefore stops exactly at `cycle_limit`.
  - Leaving HALT to RUN again with `run_cycles` ≥ `cycle_limit` runs freely until `sw_run`=0; no re-trigger.
- Not defined: the port is absent and RUN exits only on `sw_run` or `btn_reset`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `RESET_HOLD`=3, `SAMPLE_DIV_W`=4.
- Power-on: pulse `reset`, `sw_run`=0 → `core_reset`=1 for 3 cycles after release, then `state`=1, `core_ce`=0, `run_cycles`=0.
- Run then halt: `sw_run`=1 for 20 cycles, then 0 → `state`=2, `core_ce` high; `run_cycles` equals the number of `core_ce` cycles (±0); `state`=1 after 2+4+1 cycles.
- Step: in HALT, three clean `btn_step` presses → exactly three single-cycle `core_ce` pulses, `run_cycles`=3.
- Bounce: in HALT, `btn_step` toggles every 2 cycles for 20 cycles, then settles at 0 → no `core_ce` pulse, `state` stays 1.
- Reset priority: in RUN, `btn_reset` and `btn_step` edges arrive on the same debounced cycle → `state`=0, `core_ce`=0, `run_cycles`=0, `core_reset`=1 for 3 cycles, then `state`=2.
- Strobe and limit: `led_strobe` pulses exactly every 16 cycles. With the macro and `cycle_limit`=10, RUN halts with `run_cycles`=10.
